// File: rtl/gray_seq_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : gray_seq_decoder
//  Purpose  : Receiver for the 2-bit Gray state sequence
//             {A,B} = 00 -> 10 -> 11 -> 01 -> 00 (forward order).
//             Synchronizes A/B, waits out the synchronizer after reset (INIT),
//             then tracks steps (TRACK). It keeps a wrapping signed-direction
//             position count and flags two-bit (illegal) transitions.
//  Ports    : clock      - rising-edge clock
//             reset      - asynchronous, active-high reset
//             a_in, b_in - Gray bits, asynchronous to clock
//             clear      - synchronous clear of position and error
//             position   - accumulated step count (CNT_W bits, wraps)
//             dir        - direction of last valid step (1 = forward)
//             step       - one-cycle pulse per valid step
//             err_pulse  - one-cycle pulse per illegal transition
//             error      - sticky illegal-transition flag
//             valid      - high once the decoder is in TRACK
//             state_bin  - registered binary index of the synchronized code
//  Revision : 1.0 - initial release
// ============================================================================
module gray_seq_decoder #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic [CNT_W-1:0] position,
  output logic             dir,
  output logic             step,
  output logic             err_pulse,
  output logic             error,
  output logic             valid,
  output logic [1:0]       state_bin
);

  localparam int                 INIT_W    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]   POS_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [INIT_W-1:0]        r_init_cnt, w_init_cnt_nxt;
  logic [SYNC_STAGES-1:0]   r_sync_a, r_sync_b;
  logic [1:0]               r_prev_code;   // {A,B} seen on the previous cycle
  logic [1:0]               w_cur;         // synchronized {A,B}
  logic [1:0]               w_cur_bin, w_prev_bin, w_delta;
  logic                     w_inc, w_dec, w_err;

  // Gray {A,B} -> binary: 00->0, 10->1, 11->2, 01->3.
  // Upper bit is B, lower bit is A^B.
  function automatic logic [1:0] gray2bin(input logic [1:0] code);
    return {code[0], code[1] ^ code[0]};
  endfunction

  assign w_cur      = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
  assign w_cur_bin  = gray2bin(w_cur);
  assign w_prev_bin = gray2bin(r_prev_code);
  assign w_delta    = w_cur_bin - w_prev_bin;   // modulo-4 by width

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // FSM next state and step decode
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_inc          = 1'b0;
    w_dec          = 1'b0;
    w_err          = 1'b0;
    case (r_state)
      ST_INIT: begin
        // SYNC_STAGES+1 cycles flush the reset zeros out of the
        // synchronizer so prev_code holds the real input before tracking.
        if (r_init_cnt == INIT_LAST) begin
          w_state_nxt = ST_TRACK;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 1'b1;
        end
      end
      ST_TRACK: begin
        case (w_delta)
          2'd1:    w_inc = 1'b1;
          2'd3:    w_dec = 1'b1;
          2'd2:    w_err = 1'b1;
          default: ;
        endcase
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Synchronizer, code history and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync_a    <= '0;
      r_sync_b    <= '0;
      r_prev_code <= '0;
      position    <= '0;
      dir         <= 1'b0;
      step        <= 1'b0;
      err_pulse   <= 1'b0;
      error       <= 1'b0;
      valid       <= 1'b0;
      state_bin   <= '0;
    end else begin
      r_sync_a    <= {r_sync_a[SYNC_STAGES-2:0], a_in};
      r_sync_b    <= {r_sync_b[SYNC_STAGES-2:0], b_in};
      // Always advances, so a step decoded under clear is dropped rather
      // than being reported later.
      r_prev_code <= w_cur;
      state_bin   <= w_cur_bin;
      valid       <= (w_state_nxt == ST_TRACK);
      if (clear) begin
        position  <= '0;
        error     <= 1'b0;
        step      <= 1'b0;
        err_pulse <= 1'b0;
      end else begin
        step      <= w_inc | w_dec;
        err_pulse <= w_err;
        if (w_inc) begin
          position <= position + POS_ONE;
          dir      <= 1'b1;
        end else if (w_dec) begin
          position <= position - POS_ONE;
          dir      <= 1'b0;
        end
        if (w_err) begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_seq_decoder
//  Purpose  : Self-checking bench for gray_seq_decoder. Code changes are
//             driven on the falling edge; each expected step/error event is
//             queued when driven and compared when the DUT pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_seq_decoder;

  localparam int CNT_W = 8;
  localparam int SS    = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             a_in  = 1'b0;
  logic             b_in  = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] position;
  logic             dir, step, err_pulse, error, valid;
  logic [1:0]       state_bin;

  gray_seq_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clock     (clock),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .clear     (clear),
    .position  (position),
    .dir       (dir),
    .step      (step),
    .err_pulse (err_pulse),
    .error     (error),
    .valid     (valid),
    .state_bin (state_bin)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic             is_err;
    logic             dir;
    logic [CNT_W-1:0] pos;
  } ev_t;

  ev_t              sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               idx      = 0;   // model Gray index (0..3 forward order)
  logic [CNT_W-1:0] exp_pos  = '0;
  logic             exp_dir  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] code_of(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic set_idx(input int i);
    {a_in, b_in} = code_of(i);
    idx = i & 3;
  endtask

  // Move the input code by 'delta' positions in Gray order and queue the event
  // the decoder should report, then hold for 'hold' cycles.
  task automatic move(input int delta, input int hold, input bit expect_evt = 1'b1);
    int d;
    d = delta & 3;
    set_idx(idx + delta);
    if (expect_evt) begin
      if (d == 1) begin
        exp_pos = exp_pos + 1'b1;
        exp_dir = 1'b1;
        sb.push_back('{is_err: 1'b0, dir: 1'b1, pos: exp_pos});
      end else if (d == 3) begin
        exp_pos = exp_pos - 1'b1;
        exp_dir = 1'b0;
        sb.push_back('{is_err: 1'b0, dir: 1'b0, pos: exp_pos});
      end else if (d == 2) begin
        sb.push_back('{is_err: 1'b1, dir: exp_dir, pos: exp_pos});
      end
    end
    repeat (hold) @(negedge clock);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    exp_pos = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    check_val("sb_drained", sb.size(), 0);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard
  ev_t ev;
  always @(negedge clock) begin
    if (!reset) begin
      if (step && err_pulse) check_val("step_and_err_together", 1, 0);
      if (step || err_pulse) begin
        if (sb.size() == 0) begin
          check_val(step ? "unexpected_step" : "unexpected_err", 1, 0);
        end else begin
          ev = sb.pop_front();
          check_val("evt_kind_err", err_pulse, ev.is_err);
          check_val("evt_position", position, ev.pos);
          if (!ev.is_err) check_val("evt_dir", dir, ev.dir);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    set_idx(0);
    #1;
    check_val("rst_position", position, 0);
    check_val("rst_dir", dir, 0);
    check_val("rst_step", step, 0);
    check_val("rst_err_pulse", err_pulse, 0);
    check_val("rst_error", error, 0);
    check_val("rst_valid", valid, 0);
    check_val("rst_state_bin", state_bin, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // ---- 1: forward sequence ----
    repeat (SS) @(negedge clock);
    check_val("t1_valid_early", valid, 0);
    @(negedge clock);
    check_val("t1_valid_on_time", valid, 1);
    check_val("t1_state_bin", state_bin, 0);
    repeat (4) move(1, 4);
    drain();
    check_val("t1_position", position, 4);
    check_val("t1_dir", dir, 1);
    check_val("t1_error", error, 0);

    // ---- 2: backward sequence from zero ----
    do_clear();
    check_val("t2_cleared", position, 0);
    repeat (3) move(-1, 4);
    drain();
    check_val("t2_position", position, 253);
    check_val("t2_dir", dir, 0);

    // ---- 3: forward wrap ----
    do_clear();
    repeat (255) move(1, 2);
    drain();
    check_val("t3_pos_255", position, 255);
    move(1, 4);
    drain();
    check_val("t3_wrap_pos", position, 0);
    check_val("t3_error", error, 0);

    // ---- 4: illegal jump 00 -> 11 ----
    move(-1, 4);                 // 10 -> 00
    drain();
    do_clear();
    move(2, 4);                  // 00 -> 11
    drain();
    check_val("t4_error_set", error, 1);
    check_val("t4_pos_unchanged", position, 0);
    check_val("t4_state_bin", state_bin, 2);
    repeat (4) @(negedge clock);
    check_val("t4_error_sticky", error, 1);
    move(1, 4);                  // 11 -> 01
    drain();
    check_val("t4_pos_after", position, 1);
    check_val("t4_error_still", error, 1);
    do_clear();
    check_val("t4_clear_error", error, 0);
    check_val("t4_clear_pos", position, 0);

    // ---- 5: reset mid-operation with a=b=1 ----
    move(1, 4);                  // 01 -> 00, position 1
    drain();
    reset = 1'b1;
    sb.delete();
    #1;
    check_val("t5_rst_position", position, 0);
    check_val("t5_rst_valid", valid, 0);
    check_val("t5_rst_dir", dir, 0);
    check_val("t5_rst_state_bin", state_bin, 0);
    set_idx(2);
    exp_pos = '0;
    exp_dir = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (SS) @(negedge clock);
    check_val("t5_valid_early", valid, 0);
    @(negedge clock);
    check_val("t5_valid_on_time", valid, 1);
    check_val("t5_state_bin", state_bin, 2);
    repeat (6) @(negedge clock);
    check_val("t5_position", position, 0);

    // ---- 6: clear coinciding with a decoded step ----
    repeat (10) move(1, 2);
    drain();
    check_val("t6_pos_10", position, 10);
    move(1, 0, 1'b0);            // decoded on the third rising edge from here
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    exp_pos = '0;
    check_val("t6_pos_cleared", position, 0);
    check_val("t6_step_dropped", step, 0);
    check_val("t6_dir_kept", dir, 1);
    repeat (3) @(negedge clock);
    move(1, 4);
    drain();
    check_val("t6_pos_after", position, 1);

    check_val("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
